// File: rtl/isr_pkg.sv
// Shared types, default sizes and helpers for the sequential integer square root unit.
package isr_pkg;

    localparam int ISR_IN_W       = 64;
    localparam int ISR_MUL_STAGES = 8;
    localparam int ISR_MAX_W      = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_WAIT,
        S_CHECK,
        S_DONE
    } isr_state_t;

    // Index of the highest set bit; zero input yields 0.
    function automatic logic [7:0] msb_index(input logic [ISR_MAX_W-1:0] v);
        logic [7:0] idx;
        idx = '0;
        for (int i = 0; i < ISR_MAX_W; i++) begin
            if (v[i]) idx = 8'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/isr_mul_pipe.sv
// Unsigned W x W -> 2W multiplier with STAGES cycles of latency and a travelling valid bit.
module isr_mul_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_flush,
    input  logic           i_start,
    input  logic [W-1:0]   i_mcand,
    input  logic [W-1:0]   i_mplier,
    output logic [2*W-1:0] o_product,
    output logic           o_done
);

    logic [2*W-1:0]    w_a;
    logic [2*W-1:0]    w_b;
    logic [2*W-1:0]    r_prod [STAGES];
    logic [STAGES-1:0] r_vld;

    assign w_a = {{W{1'b0}}, i_mcand};
    assign w_b = {{W{1'b0}}, i_mplier};

    // Flush kills everything in flight, including a start issued in the same cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_start;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        r_prod[0] <= w_a * w_b;
        for (int i = 1; i < STAGES; i++) begin
            r_prod[i] <= r_prod[i-1];
        end
    end

    assign o_product = r_prod[STAGES-1];
    assign o_done    = r_vld[STAGES-1];

endmodule

// File: rtl/isr_seq.sv
// Sequential floor(sqrt(value)): one result bit per iteration, MSB first, by squaring a trial
// value on a pipelined multiplier. A start while busy restarts the operation.
module isr_seq
    import isr_pkg::*;
#(
    parameter int IN_W       = ISR_IN_W,
    parameter int OUT_W      = IN_W / 2,
    parameter int MUL_STAGES = ISR_MUL_STAGES,
    parameter bit SKIP_EN    = 1'b1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [IN_W-1:0]  i_value,
    output logic             o_busy,
    output logic             o_done,
    output logic [OUT_W-1:0] o_result
);

    localparam int KW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    isr_state_t       r_state;
    isr_state_t       w_state_next;
    logic [IN_W-1:0]  r_value;
    logic [OUT_W-1:0] r_work;
    logic [KW-1:0]    r_k;
    logic [IN_W-1:0]  r_prod;
    logic [OUT_W-1:0] r_result;

    logic [OUT_W-1:0] w_trial;
    logic [KW-1:0]    w_k_start;
    logic             w_keep;
    logic             w_busy;
    logic             w_done;
    logic             w_mul_start;
    logic             w_flush;
    logic [IN_W-1:0]  w_mul_product;
    logic             w_mul_done;

    assign w_trial   = r_work | (OUT_W'(1) << r_k);
    assign w_keep    = (r_prod <= r_value);
    // Starting at half the radicand's MSB skips iterations whose trial square must exceed it.
    assign w_k_start = SKIP_EN ? KW'(msb_index(ISR_MAX_W'(r_value)) >> 1) : KW'(OUT_W - 1);

    isr_mul_pipe #(
        .W      (OUT_W),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_flush   (w_flush),
        .i_start   (w_mul_start),
        .i_mcand   (w_trial),
        .i_mplier  (w_trial),
        .o_product (w_mul_product),
        .o_done    (w_mul_done)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_mul_start  = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = r_state;
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_state_next = S_FEED;
            end
            S_FEED: begin
                w_busy       = 1'b1;
                w_mul_start  = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (w_mul_done) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                w_busy       = 1'b1;
                w_state_next = (r_k == '0) ? S_DONE : S_FEED;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (i_start) begin
            w_state_next = S_LOAD;
            w_flush      = w_busy;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_value  <= '0;
            r_work   <= '0;
            r_k      <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (i_start) begin
            r_value <= i_value;
            r_work  <= '0;
        end else begin
            case (r_state)
                S_LOAD: r_k <= w_k_start;
                S_WAIT: if (w_mul_done) r_prod <= w_mul_product;
                S_CHECK: begin
                    if (w_keep) r_work <= w_trial;
                    // The final bit lands straight in the result so it is valid alongside done.
                    if (r_k != '0) r_k <= r_k - KW'(1);
                    else           r_result <= w_keep ? w_trial : r_work;
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = w_busy;
    assign o_done   = w_done;
    assign o_result = r_result;

endmodule

// File: doc/isr_seq.md
Name: isr_seq

Overview:
- Parametrised sequential integer square root unit.
- Result is floor(sqrt(value)): the largest r with r*r <= value.
- Decides one result bit per iteration, MSB first, by squaring a trial value on an internal pipelined multiplier.
- Successor of the fixed 64-bit square-root block. Adds configurable width, multiplier depth and leading-zero skip, a start/busy/done handshake, and restart-on-start.

Parameters:
- IN_W, 64: radicand width. Must be even and >= 4.
- OUT_W, IN_W/2: result width. Derived; do not override.
- MUL_STAGES, 8: multiplier latency in cycles, from mul_start to mul_done. Must be >= 1.
- SKIP_EN, 1: 1 = start iteration at bit floor(msb(value)/2); 0 = always start at bit OUT_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request. value is sampled on the same edge.
- value  in  IN_W  radicand.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  OUT_W  floor(sqrt(value)). Held stable from done until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, result=0, busy=0, done=0, multiplier pipeline valid bits cleared.
- States: IDLE, LOAD, FEED, WAIT, CHECK, DONE.
- IDLE: start=1 -> latch value, clear working result, go to LOAD.
- LOAD: compute start index k.
  - SKIP_EN=1: k = floor(msb_index(value)/2); value=0 gives k=0.
  - SKIP_EN=0: k = OUT_W-1.
  - Go to FEED.
- FEED: trial = work | (1<<k). Pulse mul_start with mcand=mplier=trial for one cycle. Go to WAIT.
- WAIT: stay until mul_done (MUL_STAGES cycles after FEED), then capture the product and go to CHECK.
- CHECK:
  - If product <= latched value (unsigned, IN_W bits), keep bit k in work.
  - If k==0, go to DONE; otherwise k--, go to FEED.
- DONE: result <= work, done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency, start edge to done-high cycle: 2 + nbits*(MUL_STAGES+2).
  - nbits = k+1 (SKIP_EN=1) or OUT_W (SKIP_EN=0).
  - Defaults worst case: 2 + 32*10 = 322 cycles (< 600 budget).
- Width: trial is OUT_W bits; product is exactly IN_W bits and cannot overflow.
- start while busy: restart.
  - Re-latch value, clear work, go to LOAD, flush the multiplier.
  - Any stale mul_done must not reach CHECK.
  - result and done are untouched until the new DONE.
- start during DONE: done still pulses with the old result; the new operation enters LOAD next cycle.
- reset mid-operation: immediate abort to the reset values; no done pulse.
- Busy outputs: busy=1 in LOAD, FEED, WAIT, CHECK. done and busy are never high together.

Decomposition:
- isr_pkg: isr_state_t enum; default constants ISR_IN_W=64 and ISR_MUL_STAGES=8; function msb_index.
- Sub-module isr_mul_pipe #(W, STAGES):
  - Unsigned W x W -> 2W pipelined multiplier.
  - Ports: clock, reset, flush, start, mcand, mplier, product, done.
  - A valid bit travels with the data; flush clears all valid bits.

Test Plan:
- Defaults, SKIP_EN=0, value=64'hFFFF_FFFF_FFFF_FFFF -> result=32'hFFFF_FFFF, done exactly 322 cycles after start, busy high 321 cycles.
- Defaults, value=0 -> result=0. value=15 -> 3. value=16 -> 4. value=64'hFFFF_FFFE_0000_0001 -> 32'hFFFF_FFFF (perfect square, <= boundary).
- SKIP_EN=1, value=16: k=2, done at 2+3*10=32 cycles, result=4.
- Restart: value=1000, then at cycle 20 start with value=81 -> single done pulse with result=9; no pulse for 1000.
- reset low mid-WAIT -> busy=0, done=0 and result=0 immediately (asynchronous). Next start with value=2 -> result=1.
- IN_W=16, MUL_STAGES=1, random 10k values -> result*result <= value < (result+1)^2 every time.
